fifo_stream_out: RTL

Read-side drain stage for the synchronous FIFO (`fifo_if`, DEPTH/WIDTH parameterised). It issues `r_en` to the FIFO and absorbs the FIFO's one-cycle read latency in a 3-entry output queue. It re-presents the data downstream as a valid/ready stream with a `m_last` marker every BURST_LEN beats. It sustains one beat per clock with no combinational path from `m_ready` to `r_en`.

---
 rtl/fifo_stream_pkg.sv | 19 +
 rtl/fifo_stream_out_q.sv | 64 ++++++
 rtl/fifo_stream_out.sv | 82 ++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared constants and pointer helpers for the FIFO read-side stream stage.
package fifo_stream_pkg;

    localparam int QDEPTH = 3;

    typedef logic [1:0] qptr_t;

    // The queue depth is not a power of two, so pointers wrap 2 -> 0 explicitly.
    function automatic qptr_t qptr_inc(input qptr_t p);
        qptr_t nxt;
        if (p == qptr_t'(QDEPTH - 1)) begin
            nxt = 2'd0;
        end else begin
            nxt = p + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_stream_out_q.sv
// Three-entry register queue that absorbs the FIFO read latency.
module stream_out_q
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem_q [QDEPTH];
    logic [WIDTH-1:0] mem_d [QDEPTH];
    qptr_t            head_q, head_d;
    qptr_t            tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = qptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        if (pop) begin
            head_d = qptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage is cleared on reset so the stream data reads zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            head_q <= 2'd0;
            tail_q <= 2'd0;
            occ_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_stream_out.sv
// FIFO drain stage: credit-based read issue, latency queue and burst-marked stream.
module fifo_stream_out
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             r_en,
    input  logic [WIDTH-1:0] data_out,
    input  logic             empty,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [15:0]      xfer_cnt
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic          inflight_q, inflight_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [15:0]   xfer_cnt_q, xfer_cnt_d;
    logic [1:0]    occ;
    logic [2:0]    pending;
    logic          pop;

    stream_out_q #(.WIDTH(WIDTH)) u_q (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (data_out),
        .pop       (pop),
        .head_data (m_data),
        .occ       (occ)
    );

    // Reads are issued only from registered credit, never from m_ready.
    always_comb begin
        pending    = {1'b0, occ} + {2'b00, inflight_q};
        r_en       = !empty && (pending < 3'(QDEPTH));
        inflight_d = r_en;
        m_valid    = (occ != 2'd0);
        m_last     = m_valid && (beat_q == LAST_BEAT);
        pop        = m_valid && m_ready;
    end

    // Burst position and transfer count advance once per accepted beat.
    always_comb begin
        beat_d     = beat_q;
        xfer_cnt_d = xfer_cnt_q;
        if (pop) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
            if (beat_q == LAST_BEAT) begin
                beat_d = '0;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end else begin
            beat_d     = beat_q;
            xfer_cnt_d = xfer_cnt_q;
        end
    end

    // Control state registers; a word in flight at reset is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            beat_q     <= '0;
            xfer_cnt_q <= 16'd0;
        end else begin
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;

endmodule
